// File: rtl/spi_byte_rx_pkg.sv
// spi_byte_rx_pkg: shared state encoding and byte/DC constants for the SPI byte receiver.
package spi_byte_rx_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;
    localparam int BYTE_W = 8;
    localparam int BIT_W = $clog2(BYTE_W);
    localparam logic DC_CMD = 1'b0;
    localparam logic DC_DATA = 1'b1;
endpackage

// File: rtl/spi_byte_rx_sync_edge.sv
// spi_byte_rx_sync_edge: N-stage synchroniser with optional history flop for edge detection.
module spi_byte_rx_sync_edge #(
    parameter int STAGES = 2,
    parameter bit RST_VAL = 1'b0,
    parameter bit HIST = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic [STAGES-1:0] sync_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= {STAGES{RST_VAL}};
        else        sync_q <= {sync_q[STAGES-2:0], d_i};
    end
    assign level_o = sync_q[STAGES-1];
    generate
        if (HIST) begin : g_hist
            logic hist_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) hist_q <= RST_VAL;
                else        hist_q <= level_o;
            end
            assign rise_o = level_o & ~hist_q;
            assign fall_o = ~level_o & hist_q;
        end else begin : g_nohist
            assign rise_o = 1'b0;
            assign fall_o = 1'b0;
        end
    endgenerate
endmodule

// File: rtl/spi_byte_rx.sv
// spi_byte_rx: oversampled SPI mode-0 slave byte receiver with D/C capture and frame pulses.
module spi_byte_rx
    import spi_byte_rx_pkg::*;
#(
    parameter bit CS_ACTIVE_LOW = 1'b1,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             Rst_n,
    input  logic             spi_sclk_in,
    input  logic             spi_mosi_in,
    input  logic             spi_cs_in,
    input  logic             dc_in,
    output logic [7:0]       data_out,
    output logic             write,
    output logic             dc_out,
    output logic             frame_start,
    output logic             frame_end,
    output logic             frame_err,
    output logic [CNT_W-1:0] byte_cnt
);
    logic sclk_rise, sclk_lvl_unused, sclk_fall_unused;
    logic cs_act, cs_rise, cs_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;
    logic dc_s, dc_rise_unused, dc_fall_unused;
    logic cs_raw;
    assign cs_raw = CS_ACTIVE_LOW ? ~spi_cs_in : spi_cs_in;

    spi_byte_rx_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .HIST(1'b1)) u_sclk (
        .clk(clk), .rst_n(Rst_n), .d_i(spi_sclk_in),
        .level_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall_unused));
    spi_byte_rx_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .HIST(1'b1)) u_cs (
        .clk(clk), .rst_n(Rst_n), .d_i(cs_raw),
        .level_o(cs_act), .rise_o(cs_rise), .fall_o(cs_fall));
    spi_byte_rx_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .HIST(1'b0)) u_mosi (
        .clk(clk), .rst_n(Rst_n), .d_i(spi_mosi_in),
        .level_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused));
    spi_byte_rx_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .HIST(1'b0)) u_dc (
        .clk(clk), .rst_n(Rst_n), .d_i(dc_in),
        .level_o(dc_s), .rise_o(dc_rise_unused), .fall_o(dc_fall_unused));

    // A frame may only start after CS has been seen inactive once the synchroniser holds real pin samples.
    logic [SYNC_STAGES-1:0] warm_q;
    logic armed_q;
    state_t state_q, state_d;
    logic [BYTE_W-1:0] shift_q, shift_d, data_q, data_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [CNT_W-1:0] byte_q, byte_d;
    logic dc_q, dc_d, done_q, done_d, write_q;
    logic fs_q, fs_d, fe_q, fe_d, ferr_q, ferr_d;

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            warm_q  <= '0;
            armed_q <= 1'b0;
            state_q <= ST_IDLE;
            shift_q <= '0;
            data_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            dc_q    <= DC_CMD;
            done_q  <= 1'b0;
            write_q <= 1'b0;
            fs_q    <= 1'b0;
            fe_q    <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            warm_q  <= {warm_q[SYNC_STAGES-2:0], 1'b1};
            armed_q <= armed_q | (warm_q[SYNC_STAGES-1] & ~cs_act);
            state_q <= state_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            dc_q    <= dc_d;
            done_q  <= done_d;
            write_q <= done_q;
            fs_q    <= fs_d;
            fe_q    <= fe_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        data_d  = data_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        dc_d    = dc_q;
        done_d  = 1'b0;
        fs_d    = 1'b0;
        fe_d    = 1'b0;
        ferr_d  = 1'b0;
        if (state_q == ST_IDLE) begin
            if (cs_rise && armed_q) begin
                state_d = ST_ACTIVE;
                fs_d    = 1'b1;
                bit_d   = '0;
                byte_d  = '0;
            end
        end else if (cs_fall) begin
            // CS release takes priority over a coincident SCLK edge.
            state_d = ST_IDLE;
            fe_d    = 1'b1;
            ferr_d  = (bit_q != '0);
            bit_d   = '0;
        end else if (sclk_rise) begin
            shift_d = {shift_q[BYTE_W-2:0], mosi_s};
            bit_d   = bit_q + BIT_W'(1);
            if (bit_q == BIT_W'(BYTE_W - 1)) begin
                data_d = {shift_q[BYTE_W-2:0], mosi_s};
                dc_d   = dc_s;
                done_d = 1'b1;
                byte_d = (&byte_q) ? byte_q : byte_q + CNT_W'(1);
            end
        end
    end

    assign data_out    = data_q;
    assign dc_out      = dc_q;
    assign write       = write_q;
    assign frame_start = fs_q;
    assign frame_end   = fe_q;
    assign frame_err   = ferr_q;
    assign byte_cnt    = byte_q;
endmodule

// File: tb/tb_spi_byte_rx.sv
// tb_spi_byte_rx: scoreboard bench for spi_byte_rx driving SPI mode-0 frames at 10 MHz SCLK.
`timescale 1ns/100ps
module tb_spi_byte_rx;
    import spi_byte_rx_pkg::*;
    localparam int CW = 4;
    localparam int HALF = 10;

    logic clk = 1'b0;
    logic Rst_n = 1'b0;
    logic sclk = 1'b0, mosi = 1'b0, cs = 1'b1, dc = 1'b0;
    logic [7:0] data_out;
    logic write, dc_out, frame_start, frame_end, frame_err;
    logic [CW-1:0] byte_cnt;

    spi_byte_rx #(.CS_ACTIVE_LOW(1'b1), .SYNC_STAGES(2), .CNT_W(CW)) dut (
        .clk(clk), .Rst_n(Rst_n), .spi_sclk_in(sclk), .spi_mosi_in(mosi),
        .spi_cs_in(cs), .dc_in(dc), .data_out(data_out), .write(write),
        .dc_out(dc_out), .frame_start(frame_start), .frame_end(frame_end),
        .frame_err(frame_err), .byte_cnt(byte_cnt));

    always #2.5 clk = ~clk;

    typedef struct packed {logic [7:0] data; logic dc;} exp_t;
    exp_t exp_q[$];
    int n_vec = 0, n_err = 0;
    int cyc = 0, rise_cyc = 0, last_wr = 0, last_fe = -1, last_ferr = -2;
    int n_wr = 0, n_fs = 0, n_fe = 0, n_ferr = 0;
    logic [3:0] prev_p = '0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        exp_t e;
        if (write) begin
            n_wr++;
            last_wr = cyc;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write got data=%02h dc=%0b want no write", data_out, dc_out);
            end else begin
                e = exp_q.pop_front();
                if ({data_out, dc_out} !== {e.data, e.dc}) begin
                    n_err++;
                    $display("FAIL write_data got data=%02h dc=%0b want data=%02h dc=%0b", data_out, dc_out, e.data, e.dc);
                end
            end
        end
        if (frame_start) n_fs++;
        if (frame_end) begin n_fe++; last_fe = cyc; end
        if (frame_err) begin n_ferr++; last_ferr = cyc; end
        if ({write, frame_start, frame_end, frame_err} != 4'b0) begin
            n_vec++;
            if (({write, frame_start, frame_end, frame_err} & prev_p) != 4'b0) begin
                n_err++;
                $display("FAIL pulse_width got %b after %b want single-cycle pulses", {write, frame_start, frame_end, frame_err}, prev_p);
            end
        end
        prev_p = {write, frame_start, frame_end, frame_err};
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input logic d, input logic cs_with_rise);
        mosi = b;
        dc = d;
        wait_cyc(HALF);
        sclk = 1'b1;
        if (cs_with_rise) cs = 1'b1;
        rise_cyc = cyc;
        wait_cyc(HALF);
        sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic d, input logic expect_wr);
        if (expect_wr) exp_q.push_back({b, d});
        for (int i = 7; i >= 0; i--) send_bit(b[i], d, 1'b0);
    endtask

    task automatic start_frame();
        cs = 1'b0;
        wait_cyc(6);
    endtask

    task automatic end_frame();
        cs = 1'b1;
        wait_cyc(6);
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            {sclk, mosi, cs, dc} = 4'($urandom_range(0, 15));
            wait_cyc(1);
            n_vec++;
            if ({data_out, dc_out, write, frame_start, frame_end, frame_err, byte_cnt} !== '0) begin
                n_err++;
                $display("FAIL reset_outputs got data=%02h dc=%0b wr=%0b fs=%0b fe=%0b ferr=%0b cnt=%0d want all 0",
                         data_out, dc_out, write, frame_start, frame_end, frame_err, byte_cnt);
            end
        end
        {sclk, mosi, cs, dc} = 4'b0010;
        wait_cyc(2);
        n_wr = 0; n_fs = 0; n_fe = 0; n_ferr = 0;
        Rst_n = 1'b1;
        wait_cyc(12);
        n_vec++;
        if ({n_wr, n_fs, n_fe, n_ferr} !== '0 || {data_out, dc_out, byte_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_release got wr=%0d fs=%0d fe=%0d ferr=%0d data=%02h cnt=%0d want all 0",
                     n_wr, n_fs, n_fe, n_ferr, data_out, byte_cnt);
        end
    endtask

    task automatic test_single_byte();
        int fs0 = n_fs, wr0 = n_wr;
        start_frame();
        send_byte(8'hA5, DC_DATA, 1'b1);
        wait_cyc(4);
        n_vec++;
        if (n_fs - fs0 !== 1 || n_wr - wr0 !== 1) begin
            n_err++;
            $display("FAIL single_counts got fs=%0d wr=%0d want fs=1 wr=1", n_fs - fs0, n_wr - wr0);
        end
        n_vec++;
        if (last_wr - rise_cyc !== 4) begin
            n_err++;
            $display("FAIL single_latency got %0d want 4", last_wr - rise_cyc);
        end
        n_vec++;
        if (byte_cnt !== CW'(1)) begin
            n_err++;
            $display("FAIL single_byte_cnt got %0d want 1", byte_cnt);
        end
        end_frame();
    endtask

    task automatic test_cmd_data();
        int fe0 = n_fe, ferr0 = n_ferr, wr0 = n_wr;
        start_frame();
        send_byte(8'h2C, DC_CMD, 1'b1);
        send_byte(8'h00, DC_DATA, 1'b1);
        send_byte(8'hFF, DC_DATA, 1'b1);
        send_byte(8'h81, DC_DATA, 1'b1);
        wait_cyc(4);
        n_vec++;
        if (byte_cnt !== CW'(4) || n_wr - wr0 !== 4) begin
            n_err++;
            $display("FAIL cmd_data_cnt got cnt=%0d wr=%0d want cnt=4 wr=4", byte_cnt, n_wr - wr0);
        end
        end_frame();
        n_vec++;
        if (n_fe - fe0 !== 1 || n_ferr - ferr0 !== 0) begin
            n_err++;
            $display("FAIL cmd_data_end got fe=%0d ferr=%0d want fe=1 ferr=0", n_fe - fe0, n_ferr - ferr0);
        end
    endtask

    task automatic test_abort();
        int fe0 = n_fe, ferr0 = n_ferr, wr0 = n_wr;
        logic [4:0] bits = 5'b10110;
        start_frame();
        for (int i = 4; i >= 0; i--) send_bit(bits[i], DC_DATA, 1'b0);
        end_frame();
        n_vec++;
        if (n_wr - wr0 !== 0 || n_fe - fe0 !== 1 || n_ferr - ferr0 !== 1 || last_fe !== last_ferr) begin
            n_err++;
            $display("FAIL abort_pulses got wr=%0d fe=%0d ferr=%0d fe_cyc=%0d err_cyc=%0d want wr=0 fe=1 ferr=1 same cycle",
                     n_wr - wr0, n_fe - fe0, n_ferr - ferr0, last_fe, last_ferr);
        end
        n_vec++;
        if (data_out !== 8'h81 || dc_out !== DC_DATA || byte_cnt !== CW'(0)) begin
            n_err++;
            $display("FAIL abort_hold got data=%02h dc=%0b cnt=%0d want data=81 dc=1 cnt=0", data_out, dc_out, byte_cnt);
        end
    endtask

    task automatic test_collision();
        int ferr0, wr0;
        logic [7:0] b = 8'h5E;
        start_frame();
        send_byte(8'h3C, DC_CMD, 1'b1);
        wait_cyc(2);
        ferr0 = n_ferr;
        wr0 = n_wr;
        for (int i = 7; i >= 1; i--) send_bit(b[i], DC_DATA, 1'b0);
        send_bit(b[0], DC_DATA, 1'b1);
        wait_cyc(4);
        n_vec++;
        if (n_wr - wr0 !== 0 || n_ferr - ferr0 !== 1) begin
            n_err++;
            $display("FAIL collision_pulses got wr=%0d ferr=%0d want wr=0 ferr=1", n_wr - wr0, n_ferr - ferr0);
        end
        n_vec++;
        if (byte_cnt !== CW'(1) || data_out !== 8'h3C || dc_out !== DC_CMD) begin
            n_err++;
            $display("FAIL collision_hold got cnt=%0d data=%02h dc=%0b want cnt=1 data=3c dc=0", byte_cnt, data_out, dc_out);
        end
    endtask

    task automatic test_saturation();
        int wr0 = n_wr, fs0;
        start_frame();
        for (int i = 0; i < 20; i++) send_byte(8'(i * 13 + 7), DC_DATA, 1'b1);
        wait_cyc(4);
        n_vec++;
        if (n_wr - wr0 !== 20 || byte_cnt !== CW'(15)) begin
            n_err++;
            $display("FAIL saturation got wr=%0d cnt=%0d want wr=20 cnt=15", n_wr - wr0, byte_cnt);
        end
        end_frame();
        fs0 = n_fs;
        start_frame();
        n_vec++;
        if (n_fs - fs0 !== 1 || byte_cnt !== CW'(0)) begin
            n_err++;
            $display("FAIL restart_clear got fs=%0d cnt=%0d want fs=1 cnt=0", n_fs - fs0, byte_cnt);
        end
        end_frame();
    endtask

    task automatic test_midframe_reset();
        int fs0, wr0;
        start_frame();
        send_bit(1'b1, DC_DATA, 1'b0);
        send_bit(1'b0, DC_DATA, 1'b0);
        Rst_n = 1'b0;
        wait_cyc(2);
        n_vec++;
        if ({data_out, dc_out, write, frame_start, frame_end, frame_err, byte_cnt} !== '0) begin
            n_err++;
            $display("FAIL midframe_reset got data=%02h dc=%0b cnt=%0d want all 0", data_out, dc_out, byte_cnt);
        end
        fs0 = n_fs;
        wr0 = n_wr;
        Rst_n = 1'b1;
        wait_cyc(10);
        send_byte(8'hC3, DC_DATA, 1'b0);
        wait_cyc(6);
        n_vec++;
        if (n_fs - fs0 !== 0 || n_wr - wr0 !== 0) begin
            n_err++;
            $display("FAIL cs_held_after_reset got fs=%0d wr=%0d want fs=0 wr=0", n_fs - fs0, n_wr - wr0);
        end
        end_frame();
        start_frame();
        send_byte(8'h96, DC_CMD, 1'b1);
        wait_cyc(4);
        n_vec++;
        if (n_fs - fs0 !== 1 || n_wr - wr0 !== 1 || byte_cnt !== CW'(1)) begin
            n_err++;
            $display("FAIL rearm_after_reset got fs=%0d wr=%0d cnt=%0d want fs=1 wr=1 cnt=1", n_fs - fs0, n_wr - wr0, byte_cnt);
        end
        end_frame();
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_cmd_data();
        test_abort();
        test_collision();
        test_saturation();
        test_midframe_reset();
        wait_cyc(10);
        n_vec++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL scoreboard_drain got %0d pending writes want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/spi_byte_rx.md
Name: spi_byte_rx

Overview:
SPI slave byte receiver, oversampled in the 200 MHz system clock domain. It sits directly upstream of the RAM command/write stage that loads the LED layers. It synchronises the SPI pins, assembles MSB-first bytes on SCLK rising edges, and latches the D/C line with each byte. It emits a one-cycle write strobe per byte plus frame start/end/error pulses.

Parameters:
CS_ACTIVE_LOW, 1, 1: spi_cs_in asserted when low; 0: asserted when high
SYNC_STAGES, 2, metastability flops per input pin, range 2..4
CNT_W, 16, width of the saturating per-frame byte counter

Ports:
clk  in  1  system clock, 200 MHz
Rst_n  in  1  asynchronous active-low reset (PLL locked)
spi_sclk_in  in  1  SPI clock, mode 0
spi_mosi_in  in  1  SPI data
spi_cs_in  in  1  chip select, polarity per CS_ACTIVE_LOW
dc_in  in  1  data/command select: 1 = data, 0 = command
data_out  out  8  last completed byte
write  out  1  one-cycle strobe; data_out and dc_out valid
dc_out  out  1  dc_in sampled with bit 0 of the byte
frame_start  out  1  one-cycle pulse on CS assertion
frame_end  out  1  one-cycle pulse on CS deassertion
frame_err  out  1  one-cycle pulse: CS deasserted with 1..7 bits pending
byte_cnt  out  CNT_W  bytes received in the current frame, saturating

Behaviour:
- Reset (async, Rst_n=0):
  - All sync flops are cleared to the idle level (sclk 0, cs inactive).
  - data_out=0, dc_out=0, write=0, frame_start=0, frame_end=0, frame_err=0, byte_cnt=0.
  - bit_cnt=0; state=IDLE.
- Sync:
  - sclk, mosi, cs and dc each pass through SYNC_STAGES flops.
  - One extra history flop on sclk and on cs supports edge detection.
  - sclk_rise = sync & ~hist. cs_act is the synced CS, normalised to active-high.
- FSM, 2 states:
  - IDLE: on cs_act rising, go to ACTIVE, pulse frame_start, clear bit_cnt and byte_cnt. SCLK edges are ignored in IDLE.
  - ACTIVE:
    - On sclk_rise: shift = {shift[6:0], mosi_sync}; bit_cnt++.
    - On sclk_rise with bit_cnt==7: data_out <= {shift[6:0], mosi_sync}, dc_out <= dc_sync, write=1 on the next cycle, bit_cnt wraps to 0, byte_cnt++ (holds at all-ones).
    - On cs_act falling: go to IDLE and pulse frame_end. If bit_cnt!=0, also pulse frame_err and discard the partial byte (no write). data_out, dc_out and byte_cnt hold.
- Latency: write asserts exactly SYNC_STAGES+2 clk cycles after the pin-level 8th SCLK rising edge (4 at default).
- Simultaneous events: if sclk_rise and cs_act falling occur in the same cycle, CS wins and the edge is discarded.
- Input timing: SCLK high and low phases must each be ≥3 clk periods. MOSI and DC must be stable ≥3 clk before a SCLK rise.
- write, frame_start, frame_end and frame_err are never asserted for more than one cycle.
- Mid-frame reset returns everything to reset values. After Rst_n releases with CS already active, the block stays in IDLE until CS deasserts and then reasserts.

Decomposition:
- Shared package holds the state encoding (ST_IDLE, ST_ACTIVE), BYTE_W=8, and the DC_CMD=0 / DC_DATA=1 constants.
- One natural sub-module, sync_edge: N-stage synchroniser plus history flop, outputting the level, rise and fall. It is instantiated for sclk and cs; mosi and dc use the level output only.

Test Plan:
- Reset: Rst_n=0 with random pins toggling -> all outputs 0. Release Rst_n with CS inactive -> outputs stay 0 and no pulses appear.
- Single byte: CS assert, dc=1, send 0xA5 MSB-first at 10 MHz SCLK -> frame_start once; one write with data_out=0xA5, dc_out=1, 4 cycles after the 8th rise; byte_cnt=1.
- Command then data: send 0x2C with dc=0, then 0x00,0xFF,0x81 with dc=1 in one frame -> 4 writes with dc_out sequence 0,1,1,1 and byte_cnt=4; frame_end on CS release; frame_err=0.
- Abort: CS asserts, 5 bits of 0b10110 are sent, then CS releases -> no write; frame_end and frame_err pulse in the same cycle; data_out holds its previous value.
- Collision: 8th SCLK rise and CS deassert land in the same synced cycle -> no write, frame_err=1, byte_cnt unchanged.
- Saturation: with CNT_W=4, send 20 bytes in one frame -> byte_cnt stops at 15; all 20 writes still occur. The next frame_start clears byte_cnt to 0.
